// File: rtl/data_sync_hs_pkg.sv
// data_sync_hs_pkg: shared CDC types and default widths
package data_sync_hs_pkg;
  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;
  localparam int NUM_STAGES_DEF = 2;
  localparam int BUS_WIDTH_DEF = 8;
endpackage

// File: rtl/data_sync_hs_if.sv
// data_sync_hs_if: bus + four-phase handshake between source side and the synchronizer
// master: drives unsync_bus/bus_enable, observes sync_bus/enable_pulse/bus_ack/busy
// slave: the synchronizer, the mirror image of master
interface data_sync_hs_if import data_sync_hs_pkg::*; #(parameter int BUS_WIDTH = BUS_WIDTH_DEF) ();
  logic [BUS_WIDTH-1:0] unsync_bus;
  logic bus_enable;
  logic [BUS_WIDTH-1:0] sync_bus;
  logic enable_pulse;
  logic bus_ack;
  logic busy;
  modport master(output unsync_bus, bus_enable, input sync_bus, enable_pulse, bus_ack, busy);
  modport slave(input unsync_bus, bus_enable, output sync_bus, enable_pulse, bus_ack, busy);
endinterface

// File: rtl/data_sync_hs_bit_sync_chain.sv
// bit_sync_chain: single-bit multi-flop synchronizer, sync active-low reset
// clk: sampling clock, rst_n: reset, d: async input, q: synchronized output
module bit_sync_chain #(parameter int NUM_Stages = 2) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [NUM_Stages-1:0] ff;
  always_ff @(posedge clk)
    if (!rst_n) ff <= '0;
    else ff <= {ff[NUM_Stages-2:0], d};
  assign q = ff[NUM_Stages-1];
endmodule

// File: rtl/data_sync_hs.sv
// data_sync_hs: destination-side bus synchronizer with enable-level request and registered ack
// CLK: domain clock, sync_Reset: active-low synchronous reset
// bus (slave): unsync_bus/bus_enable in; sync_bus/enable_pulse/bus_ack/busy out, all registered
module data_sync_hs import data_sync_hs_pkg::*; #(
  parameter int NUM_Stages = NUM_STAGES_DEF,
  parameter int BUS_WIDTH = BUS_WIDTH_DEF
) (
  input logic CLK,
  input logic sync_Reset,
  data_sync_hs_if.slave bus
);
  state_t state, state_n;
  logic en_sync, en_prev, en_rise, load;
  logic [BUS_WIDTH-1:0] data_q;
  logic pulse_q, ack_q;
  bit_sync_chain #(.NUM_Stages(NUM_Stages)) u_en_sync (
    .clk(CLK),
    .rst_n(sync_Reset),
    .d(bus.bus_enable),
    .q(en_sync)
  );
  // en_prev resets to 0 so a request already high at reset release counts as a new transfer
  assign en_rise = en_sync & ~en_prev;
  always_comb begin
    load = (state == IDLE) & en_rise;
    state_n = load ? ACK : ((state == ACK) && !en_sync) ? IDLE : state;
  end
  always_ff @(posedge CLK)
    if (!sync_Reset) begin
      state <= IDLE;
      en_prev <= 1'b0;
      data_q <= '0;
      pulse_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      state <= state_n;
      en_prev <= en_sync;
      if (load) data_q <= bus.unsync_bus;
      pulse_q <= load;
      ack_q <= (state_n == ACK);
    end
  assign bus.sync_bus = data_q;
  assign bus.enable_pulse = pulse_q;
  assign bus.bus_ack = ack_q;
  assign bus.busy = (state == ACK);
endmodule
